// File: rtl/vx_dispatch_arbiter_pkg.sv
// Shared types and helpers for the dispatch arbiter: lock state encoding and
// requester-index width derivation.
package vx_dispatch_arbiter_pkg;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

    // Index width for a requester count; a single requester still gets one bit.
    function automatic int req_bits(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_arbiter_rr.sv
// Round-robin priority pick: first valid requester scanning circularly from
// rr_ptr. Purely combinational; pointer and lock handling live in the parent.
module vx_dispatch_arbiter_rr #(
    parameter int NUM_REQS = 4,
    parameter int REQ_BITS = 2
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [REQ_BITS-1:0] rr_ptr,
    output logic                grant_valid,
    output logic [REQ_BITS-1:0] grant_idx
);

    // One extra bit so rr_ptr + offset can exceed NUM_REQS before wrapping.
    logic [REQ_BITS:0]   cand_idx [NUM_REQS];
    logic [NUM_REQS-1:0] cand_valid;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_cand
            logic [REQ_BITS:0] sum;
            assign sum = {1'b0, rr_ptr} + (REQ_BITS+1)'(gi);
            assign cand_idx[gi] = (sum >= (REQ_BITS+1)'(NUM_REQS))
                                ? sum - (REQ_BITS+1)'(NUM_REQS)
                                : sum;
            assign cand_valid[gi] = valid[cand_idx[gi][REQ_BITS-1:0]];
        end
    endgenerate

    // Scan from the far end so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[i][REQ_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/vx_dispatch_arbiter.sv
// Packet-aware arbiter merging NUM_REQS issue slices onto one execution unit
// through a single registered output stage; a multi-beat packet holds the grant.
module vx_dispatch_arbiter
    import vx_dispatch_arbiter_pkg::*;
#(
    parameter  int NUM_REQS = 4,
    parameter  int DATAW    = 64,
    localparam int REQ_BITS = req_bits(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            valid_in,
    input  logic [NUM_REQS-1:0][DATAW-1:0] data_in,
    input  logic [NUM_REQS-1:0]            sop_in,
    input  logic [NUM_REQS-1:0]            eop_in,
    output logic [NUM_REQS-1:0]            ready_in,
    output logic                           valid_out,
    output logic [DATAW-1:0]               data_out,
    output logic                           sop_out,
    output logic                           eop_out,
    output logic [REQ_BITS-1:0]            sel_out,
    input  logic                           ready_out
);

    lock_state_e         state_q, state_d;
    logic [REQ_BITS-1:0] lock_idx_q, lock_idx_d;
    logic [REQ_BITS-1:0] rr_ptr_q, rr_ptr_d;

    logic                valid_q, valid_d;
    logic [DATAW-1:0]    data_q, data_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic [REQ_BITS-1:0] sel_q, sel_d;

    logic                pick_valid;
    logic [REQ_BITS-1:0] pick_idx;
    logic                grant_any;
    logic [REQ_BITS-1:0] grant_idx;
    logic [NUM_REQS-1:0] grant;
    logic                out_ready;
    logic                fire;
    logic [DATAW-1:0]    win_data;
    logic                win_sop;
    logic                win_eop;

    function automatic logic [REQ_BITS-1:0] wrap_inc(input logic [REQ_BITS-1:0] idx);
        return (idx == REQ_BITS'(NUM_REQS - 1)) ? '0 : idx + 1'b1;
    endfunction

    vx_dispatch_arbiter_rr #(
        .NUM_REQS (NUM_REQS),
        .REQ_BITS (REQ_BITS)
    ) u_rr (
        .valid       (valid_in),
        .rr_ptr      (rr_ptr_q),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    // The output register can take a beat when empty or draining this cycle.
    assign out_ready = ~valid_q | ready_out;

    // While locked the owner keeps the grant even when it is not presenting a beat.
    always_comb begin
        grant_any = (state_q == LOCK_LOCKED) | pick_valid;
        grant_idx = (state_q == LOCK_LOCKED) ? lock_idx_q : pick_idx;
    end

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
            assign grant[gi]    = grant_any && (grant_idx == REQ_BITS'(gi));
            assign ready_in[gi] = grant[gi] & out_ready & ~reset;
        end
    endgenerate

    always_comb begin
        fire     = 1'b0;
        win_data = '0;
        win_sop  = 1'b0;
        win_eop  = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (valid_in[i] && ready_in[i]) begin
                fire     = 1'b1;
                win_data = data_in[i];
                win_sop  = sop_in[i];
                win_eop  = eop_in[i];
            end
        end
    end

    // Lock FSM and round-robin pointer.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            LOCK_UNLOCKED: begin
                if (fire && !win_eop) begin
                    state_d    = LOCK_LOCKED;
                    lock_idx_d = grant_idx;
                end
            end
            LOCK_LOCKED: begin
                if (fire && win_eop) begin
                    state_d = LOCK_UNLOCKED;
                end
            end
            default: state_d = LOCK_UNLOCKED;
        endcase
        if (fire && win_eop) begin
            rr_ptr_d = wrap_inc(grant_idx);
        end
    end

    // Output stage: load on fire, otherwise clear valid once drained.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        sel_d   = sel_q;
        if (fire) begin
            valid_d = 1'b1;
            data_d  = win_data;
            sop_d   = win_sop;
            eop_d   = win_eop;
            sel_d   = grant_idx;
        end else if (ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOCK_UNLOCKED;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            sel_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            sel_q      <= sel_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;
    assign sel_out   = sel_q;

endmodule

// File: tb/tb_vx_dispatch_arbiter.sv
// Bench for vx_dispatch_arbiter: directed scenarios plus a randomized run
// checked against a packet-level reference model and scoreboard.
module tb_vx_dispatch_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          valid_in, sop_in, eop_in, ready_in;
    logic [N-1:0][DW-1:0]  data_in;
    logic                  valid_out, sop_out, eop_out, ready_out;
    logic [DW-1:0]         data_out;
    logic [1:0]            sel_out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    vx_dispatch_arbiter #(.NUM_REQS(N), .DATAW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sop_in    (sop_in),
        .eop_in    (eop_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sop_out   (sop_out),
        .eop_out   (eop_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
    );

    function automatic logic [DW-1:0] pat(input int i, input int tag);
        return {16'hC0DE, 8'(i), 40'(tag)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] s,
                          input logic [N-1:0] e, input int tag);
        valid_in = v;
        sop_in   = s;
        eop_in   = e;
        for (int i = 0; i < N; i++) data_in[i] = pat(i, tag);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        ready_out = 1'b1;
        set_in('0, '0, '0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ready_out = 1'b1;
        set_in(4'hF, 4'hF, 4'hF, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            tests_run++;
            if (ready_in !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_ready got=%b exp=0000", ready_in);
            end
            tests_run++;
            if ({valid_out, sop_out, eop_out, sel_out, data_out} !== 69'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs got v=%b s=%b e=%b sel=%0d d=%h exp all zero",
                         valid_out, sop_out, eop_out, sel_out, data_out);
            end
        end
        reset = 1'b0;
        set_in('0, '0, '0, 0);
        step();
        $display("[TB] reset: outputs and ready_in held at zero");
    endtask

    task automatic test_round_robin();
        do_reset();
        set_in(4'hF, 4'hF, 4'hF, 1);
        #1;
        tests_run++;
        if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_first_latency got valid_out=%b exp=0", valid_out);
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (ready_in !== 4'(1 << (k % 4))) begin
                tests_failed++;
                $display("FAIL rr_ready[%0d] got=%b exp=%b", k, ready_in, 4'(1 << (k % 4)));
            end
            step();
            tests_run++;
            if ({valid_out, sop_out, eop_out, sel_out, data_out} !==
                {1'b1, 1'b1, 1'b1, 2'(k % 4), pat(k % 4, 1)}) begin
                tests_failed++;
                $display("FAIL rr_beat[%0d] got v=%b sel=%0d d=%h exp v=1 sel=%0d d=%h",
                         k, valid_out, sel_out, data_out, k % 4, pat(k % 4, 1));
            end
            $display("[TB] rr beat %0d sel=%0d data=%h", k, sel_out, data_out);
        end
        set_in('0, '0, '0, 0);
        step();
        tests_run++;
        if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_drain got valid_out=%b exp=0", valid_out);
        end
    endtask

    task automatic test_locked_packet();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            set_in(4'b0110, 4'b0100 | ((b == 0) ? 4'b0010 : 4'b0000),
                   4'b0100 | ((b == 2) ? 4'b0010 : 4'b0000), 10 + b);
            #1;
            tests_run++;
            if (ready_in !== 4'b0010) begin
                tests_failed++;
                $display("FAIL lock_ready[%0d] got=%b exp=0010", b, ready_in);
            end
            step();
            tests_run++;
            if ({valid_out, sop_out, eop_out, sel_out, data_out} !==
                {1'b1, (b == 0), (b == 2), 2'd1, pat(1, 10 + b)}) begin
                tests_failed++;
                $display("FAIL lock_beat[%0d] got v=%b s=%b e=%b sel=%0d d=%h exp sel=1 d=%h",
                         b, valid_out, sop_out, eop_out, sel_out, data_out, pat(1, 10 + b));
            end
            $display("[TB] lock beat %0d sel=%0d data=%h", b, sel_out, data_out);
        end
        tests_run++;
        if (ready_in !== 4'b0100) begin
            tests_failed++;
            $display("FAIL lock_next_ready got=%b exp=0100", ready_in);
        end
        step();
        tests_run++;
        if ({valid_out, sel_out, data_out} !== {1'b1, 2'd2, pat(2, 12)}) begin
            tests_failed++;
            $display("FAIL lock_next_beat got v=%b sel=%0d d=%h exp sel=2 d=%h",
                     valid_out, sel_out, data_out, pat(2, 12));
        end
        set_in('0, '0, '0, 0);
        step();
    endtask

    task automatic test_lock_gap();
        do_reset();
        set_in(4'b1010, 4'b1010, 4'b1000, 20);
        #1;
        step();
        tests_run++;
        if ({valid_out, sop_out, eop_out, sel_out} !== {1'b1, 1'b1, 1'b0, 2'd1}) begin
            tests_failed++;
            $display("FAIL gap_start got v=%b s=%b e=%b sel=%0d exp v=1 s=1 e=0 sel=1",
                     valid_out, sop_out, eop_out, sel_out);
        end
        for (int g = 0; g < 2; g++) begin
            set_in(4'b1000, 4'b1000, 4'b1000, 21);
            #1;
            tests_run++;
            if (ready_in !== 4'b0010) begin
                tests_failed++;
                $display("FAIL gap_ready[%0d] got=%b exp=0010", g, ready_in);
            end
            step();
            tests_run++;
            if (valid_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL gap_no_output[%0d] got valid_out=%b exp=0", g, valid_out);
            end
        end
        set_in(4'b1010, 4'b1000, 4'b1010, 22);
        #1;
        tests_run++;
        if (ready_in !== 4'b0010) begin
            tests_failed++;
            $display("FAIL gap_resume_ready got=%b exp=0010", ready_in);
        end
        step();
        tests_run++;
        if ({valid_out, sop_out, eop_out, sel_out, data_out} !==
            {1'b1, 1'b0, 1'b1, 2'd1, pat(1, 22)}) begin
            tests_failed++;
            $display("FAIL gap_resume_beat got v=%b s=%b e=%b sel=%0d d=%h exp sel=1 eop d=%h",
                     valid_out, sop_out, eop_out, sel_out, data_out, pat(1, 22));
        end
        tests_run++;
        if (ready_in !== 4'b1000) begin
            tests_failed++;
            $display("FAIL gap_after_ready got=%b exp=1000", ready_in);
        end
        step();
        tests_run++;
        if ({valid_out, sel_out, data_out} !== {1'b1, 2'd3, pat(3, 22)}) begin
            tests_failed++;
            $display("FAIL gap_after_beat got sel=%0d d=%h exp sel=3 d=%h",
                     sel_out, data_out, pat(3, 22));
        end
        $display("[TB] lock gap resumed, last sel=%0d", sel_out);
        set_in('0, '0, '0, 0);
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_in(4'b0001, 4'b0001, 4'b0001, 0);
        data_in[0] = 64'hA5;
        step();
        tests_run++;
        if ({valid_out, sel_out, data_out} !== {1'b1, 2'd0, 64'hA5}) begin
            tests_failed++;
            $display("FAIL bp_load got v=%b sel=%0d d=%h exp v=1 sel=0 d=a5",
                     valid_out, sel_out, data_out);
        end
        ready_out = 1'b0;
        set_in(4'b0101, 4'b0101, 4'b0101, 30);
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (ready_in !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready[%0d] got=%b exp=0000", c, ready_in);
            end
            step();
            tests_run++;
            if ({valid_out, sop_out, eop_out, sel_out, data_out} !==
                {1'b1, 1'b1, 1'b1, 2'd0, 64'hA5}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got v=%b sel=%0d d=%h exp v=1 sel=0 d=a5",
                         c, valid_out, sel_out, data_out);
            end
        end
        ready_out = 1'b1;
        #1;
        tests_run++;
        if (ready_in !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_release_ready got=%b exp=0100", ready_in);
        end
        step();
        tests_run++;
        if ({valid_out, sel_out, data_out} !== {1'b1, 2'd2, pat(2, 30)}) begin
            tests_failed++;
            $display("FAIL bp_release_beat got sel=%0d d=%h exp sel=2 d=%h",
                     sel_out, data_out, pat(2, 30));
        end
        $display("[TB] backpressure released, sel=%0d data=%h", sel_out, data_out);
        set_in('0, '0, '0, 0);
        step();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        set_in(4'b0100, 4'b0100, 4'b0000, 40);
        step();
        tests_run++;
        if ({valid_out, eop_out, sel_out} !== {1'b1, 1'b0, 2'd2}) begin
            tests_failed++;
            $display("FAIL rmp_start got v=%b e=%b sel=%0d exp v=1 e=0 sel=2",
                     valid_out, eop_out, sel_out);
        end
        reset = 1'b1;
        set_in(4'b0101, 4'b0101, 4'b0101, 41);
        #1;
        tests_run++;
        if (ready_in !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rmp_ready_in_reset got=%b exp=0000", ready_in);
        end
        step();
        reset = 1'b0;
        tests_run++;
        if ({valid_out, sop_out, eop_out, sel_out, data_out} !== 69'd0) begin
            tests_failed++;
            $display("FAIL rmp_cleared got v=%b sel=%0d d=%h exp all zero",
                     valid_out, sel_out, data_out);
        end
        #1;
        tests_run++;
        if (ready_in !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rmp_priority got=%b exp=0001", ready_in);
        end
        step();
        tests_run++;
        if ({valid_out, sel_out, data_out} !== {1'b1, 2'd0, pat(0, 41)}) begin
            tests_failed++;
            $display("FAIL rmp_beat got sel=%0d d=%h exp sel=0 d=%h",
                     sel_out, data_out, pat(0, 41));
        end
        $display("[TB] reset mid-packet, winner sel=%0d", sel_out);
        set_in('0, '0, '0, 0);
        step();
    endtask

    task automatic test_random();
        int unsigned len[N], beat[N], pkt[N], waits[N];
        int unsigned out_beat[N], out_pkt[N];
        logic [N-1:0]  v, exp_ready;
        logic          m_locked, ro;
        int            m_idx, m_rr, g, open_owner, drains, max_wait, s;
        logic [DW-1:0] q_data[$];
        int            q_sel[$];
        logic          q_sop[$], q_eop[$];

        do_reset();
        for (int i = 0; i < N; i++) begin
            len[i] = 1; beat[i] = 0; pkt[i] = 0; waits[i] = 0;
            out_beat[i] = 0; out_pkt[i] = 0;
        end
        v = '0; m_locked = 1'b0; m_idx = 0; m_rr = 0;
        open_owner = -1; drains = 0; max_wait = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            tests_run++;
            if (q_sel.size() == 0) begin
                if (valid_out !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rnd_idle[%0d] got valid_out=%b exp=0", cyc, valid_out);
                end
            end else if ({valid_out, sop_out, eop_out, sel_out, data_out} !==
                         {1'b1, q_sop[0], q_eop[0], 2'(q_sel[0]), q_data[0]}) begin
                tests_failed++;
                $display("FAIL rnd_beat[%0d] got v=%b sel=%0d d=%h exp v=1 sel=%0d d=%h",
                         cyc, valid_out, sel_out, data_out, q_sel[0], q_data[0]);
            end

            // A requester holds a packet-start beat until it is taken.
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    if (beat[i] == 0) len[i] = $urandom_range(1, 4);
                end
                data_in[i] = {8'(i), 24'(pkt[i]), 32'(beat[i])};
                sop_in[i]  = (beat[i] == 0);
                eop_in[i]  = (beat[i] == len[i] - 1);
            end
            valid_in  = v;
            ro        = ($urandom_range(0, 3) != 0);
            ready_out = ro;

            g = -1;
            if (m_locked) g = m_idx;
            else for (int k = 0; k < N; k++) if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
            exp_ready = '0;
            if (g >= 0 && (q_sel.size() == 0 || ro)) exp_ready[g] = 1'b1;

            #1;
            tests_run++;
            if (ready_in !== exp_ready) begin
                tests_failed++;
                $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, ready_in, exp_ready);
            end

            if (q_sel.size() != 0 && ro) begin
                s = int'(sel_out);
                tests_run++;
                if ((open_owner >= 0 && s != open_owner) ||
                    data_out !== {8'(s), 24'(out_pkt[s]), 32'(out_beat[s])}) begin
                    tests_failed++;
                    $display("FAIL rnd_order[%0d] got sel=%0d d=%h exp owner=%0d pkt=%0d beat=%0d",
                             cyc, s, data_out, open_owner, out_pkt[s], out_beat[s]);
                end
                if (eop_out) begin
                    open_owner  = -1;
                    out_beat[s] = 0;
                    out_pkt[s]++;
                end else begin
                    open_owner = s;
                    out_beat[s]++;
                end
                void'(q_data.pop_front()); void'(q_sel.pop_front());
                void'(q_sop.pop_front());  void'(q_eop.pop_front());
                drains++;
            end

            if (g >= 0 && exp_ready[g] && v[g]) begin
                q_data.push_back(data_in[g]); q_sel.push_back(g);
                q_sop.push_back(sop_in[g]);   q_eop.push_back(eop_in[g]);
                if (beat[g] == 0) begin
                    tests_run++;
                    if (waits[g] > N - 1) begin
                        tests_failed++;
                        $display("FAIL rnd_wait req=%0d got=%0d packets exp<=%0d", g, waits[g], N - 1);
                    end
                    if (int'(waits[g]) > max_wait) max_wait = int'(waits[g]);
                    waits[g] = 0;
                end
                if (eop_in[g]) begin
                    for (int j = 0; j < N; j++) if (j != g && v[j] && beat[j] == 0) waits[j]++;
                    m_locked = 1'b0;
                    m_rr     = (g + 1) % N;
                    beat[g]  = 0;
                    pkt[g]++;
                end else begin
                    m_locked = 1'b1;
                    m_idx    = g;
                    beat[g]++;
                end
                v[g] = 1'b0;
            end
            step();
        end
        valid_in  = '0;
        ready_out = 1'b1;
        step();
        tests_run++;
        if (drains < 1000) begin
            tests_failed++;
            $display("FAIL rnd_activity got=%0d drained beats exp>=1000", drains);
        end
        $display("[TB] random: %0d beats drained, max wait %0d packets", drains, max_wait);
    endtask

    initial begin
        reset     = 1'b1;
        ready_out = 1'b1;
        valid_in  = '0;
        sop_in    = '0;
        eop_in    = '0;
        data_in   = '0;
        test_reset();
        test_round_robin();
        test_locked_packet();
        test_lock_gap();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vx_dispatch_arbiter.md
VX_DISPATCH_ARBITER -- requirements
Module: VX_dispatch_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of issue slices sharing one execution unit; legal range 1..16.
REQ-002 SHALL have parameter DATAW, default 64: payload width in bits, excluding sop/eop.
REQ-003 SHALL have port clk, input, 1 bit: single clock. All logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port valid_in, input, NUM_REQS bits: per-requester beat valid.
REQ-006 SHALL have port data_in, input, NUM_REQS x DATAW bits: per-requester payload.
REQ-007 SHALL have ports sop_in and eop_in, input, NUM_REQS bits each: per-requester packet start and end markers.
REQ-008 SHALL have port ready_in, output, NUM_REQS bits: per-requester accept.
REQ-009 SHALL have ports valid_out (1 bit), data_out (DATAW bits), sop_out (1 bit) and eop_out (1 bit), all outputs: registered winning beat.
REQ-010 SHALL have port sel_out, output, REQ_BITS = max(1, clog2(NUM_REQS)) bits: index of the requester that supplied the beat on data_out.
REQ-011 SHALL have port ready_out, input, 1 bit: downstream accept.

Function
REQ-012 SHALL transfer a beat on an input when valid_in[i] && ready_in[i], and on the output when valid_out && ready_out.
REQ-013 SHALL register the output stage: latency from input fire to valid_out is exactly 1 cycle, and sustained throughput is 1 beat per cycle when ready_out is held at 1.
REQ-014 SHALL drive ready_in[i] = grant[i] && (~valid_out || ready_out), with at most one grant bit set in any cycle.
REQ-015 SHALL implement a two-state FSM with states UNLOCKED and LOCKED(idx).
REQ-016 In UNLOCKED, SHALL grant the first valid requester found scanning circularly from rr_ptr (rr_ptr, rr_ptr+1, ... modulo NUM_REQS).
REQ-017 In LOCKED(idx), SHALL make only requester idx eligible for grant; all other ready_in bits SHALL be 0, even while idx is invalid.
REQ-018 SHALL transition UNLOCKED -> LOCKED(w) when a beat from winner w fires with eop_in[w]=0.
REQ-019 SHALL transition LOCKED(idx) -> UNLOCKED when a beat from idx fires with eop_in[idx]=1.
REQ-020 SHALL update rr_ptr to (w+1) mod NUM_REQS on every fired eop beat, and SHALL NOT change rr_ptr otherwise.
REQ-021 SHALL treat a beat with sop=1 and eop=1 as a complete packet: the FSM stays UNLOCKED and rr_ptr advances.
REQ-022 SHALL accept a beat with sop=0 arriving in UNLOCKED as a packet start, with no error flag.
REQ-023 SHALL pass sop_in and eop_in through unchanged to sop_out and eop_out alongside their beat.
REQ-024 SHALL hold valid_out, data_out, sop_out, eop_out and sel_out stable while valid_out && ~ready_out.
REQ-025 SHALL accept a new beat in the same cycle the output beat drains, with no bubble.
REQ-026 With NUM_REQS=1, SHALL reduce to a plain pipeline register, with sel_out held at 0.

Reset
REQ-027 SHALL, while reset is high, force: valid_out=0, sop_out=0, eop_out=0, data_out=0, sel_out=0, FSM=UNLOCKED, rr_ptr=0.
REQ-028 SHALL, on reset asserted mid-packet, drop the held beat and the lock; the first cycle after reset gives priority to requester 0.
REQ-029 SHALL keep ready_in at 0 during every cycle in which reset is high.

Structure
REQ-030 SHALL take REQ_BITS from a clog2-based localparam; no new typedefs are added to VX_gpu_pkg.
REQ-031 SHALL instantiate one sub-module: the round-robin priority pick, as VX_rr_arbiter, with lock and rr_ptr update kept in this module. Alternatively the pick SHALL be inline.
REQ-032 SHALL be instantiated by the issue stage once per execution unit, with inputs fed from the per-slice dispatch_if[ex] outputs of each issue slice.

Verification
REQ-033 Scenario: NUM_REQS=4, all requesters valid with single-beat packets (sop=eop=1), ready_out=1 -> sel_out sequence 0,1,2,3,0 on consecutive cycles, first valid_out the cycle after the first input fire.
REQ-034 Scenario: requester 1 sends a 3-beat packet (sop on beat 0, eop on beat 2) while requester 2 stays valid -> three consecutive outputs with sel_out=1, then sel_out=2; ready_in[2]=0 throughout the packet.
REQ-035 Scenario: LOCKED(1) with valid_in[1] dropped for 2 cycles while requester 3 is valid -> no output beats and ready_in[3]=0 during the gap; the lock resumes when requester 1 returns.
REQ-036 Scenario: ready_out=0 for 3 cycles with valid_out=1 and data_out=0xA5 -> outputs remain stable, all ready_in=0; when ready_out returns to 1, the next beat is accepted in the same cycle.
REQ-037 Scenario: reset pulsed while in LOCKED(2) -> the next cycle shows valid_out=0 and UNLOCKED; with requesters 0 and 2 both valid, requester 0 wins.
REQ-038 Scenario: random valid, ready and packet lengths over 10k cycles -> a scoreboard sees no interleaving of beats within any packet, no lost or duplicated beats, and the maximum wait for any requester is at most (NUM_REQS-1) packets.
